// File: rtl/sdiv_pkg.sv
// +----------------------------------------------------------------------------+
// | sdiv_pkg : shared types and helpers for the sequential signed divider      |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

package sdiv_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } sdiv_state_t;

   // Counter must hold the value W, hence one bit beyond $clog2(W).
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sdiv_if.sv
// +----------------------------------------------------------------------------+
// | sdiv_if  : start/done request bus between requester and sdiv_seq           |
// | Rev 1.0  : initial release; div_by_zero present with SDIV_DIVZERO_EN       |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sdiv_if #(
   parameter int W = 8
) ();
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
`ifdef SDIV_DIVZERO_EN
   logic         div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );
   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
`else
   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder
   );
   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder
   );
`endif
endinterface

`default_nettype wire

// File: rtl/sdiv_step.sv
// +----------------------------------------------------------------------------+
// | sdiv_step : one combinational restoring-division iteration                 |
// | Rev 1.0   : initial release                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module sdiv_step #(
   parameter int W = 8
) (
   input  logic [W:0]   p,
   input  logic [W-1:0] a,
   input  logic [W:0]   d,
   output logic [W:0]   p_next,
   output logic [W-1:0] a_next
);
   logic [W:0]   p_sh;
   logic [W+1:0] diff;
   logic         ge;
   logic         unused_p_msb;

   // The partial remainder stays below |D| <= 2^(W-1), so its top bit never shifts out.
   assign unused_p_msb = p[W];

   assign p_sh   = {p[W-1:0], a[W-1]};
   assign diff   = {p_sh[W], p_sh} - {d[W], d};
   assign ge     = ~diff[W+1];
   assign p_next = ge ? diff[W:0] : p_sh;
   assign a_next = {a[W-2:0], ge};

endmodule

`default_nettype wire

// File: rtl/sdiv_seq.sv
// +----------------------------------------------------------------------------+
// | sdiv_seq : multi-cycle signed restoring divider, one quotient bit/cycle    |
// | Option   : SDIV_DIVZERO_EN adds divide-by-zero detection and flag          |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module sdiv_seq
   import sdiv_pkg::*;
#(
   parameter int W = 8
) (
   input logic  clk,
   input logic  rst,
   sdiv_if.slave bus
);
   localparam int            CW   = cnt_width(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   sdiv_state_t   state;
   sdiv_state_t   next_state;
   logic [CW-1:0] count;
   logic [W-1:0]  dvd;
   logic [W-1:0]  dvs;
   logic          sign_q;
   logic          sign_r;
   logic [W-1:0]  a_reg;
   logic [W:0]    p_reg;
   logic [W:0]    d_reg;
   logic [W-1:0]  quo;
   logic [W-1:0]  rem;
   logic [W:0]    dvs_ext;
   logic [W:0]    dvs_mag;
   logic [W-1:0]  dvd_mag;
   logic [W:0]    p_next;
   logic [W-1:0]  a_next;
`ifdef SDIV_DIVZERO_EN
   logic          dz;
`endif

   // A W-bit negate of -2^(W-1) yields 2^(W-1) as an unsigned magnitude.
   assign dvd_mag = dvd[W-1] ? -dvd : dvd;
   assign dvs_ext = {dvs[W-1], dvs};
   assign dvs_mag = dvs[W-1] ? -dvs_ext : dvs_ext;

   sdiv_step #(.W(W)) u_step (
      .p      (p_reg),
      .a      (a_reg),
      .d      (d_reg),
      .p_next (p_next),
      .a_next (a_next)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: if (bus.start) next_state = LOAD;
`ifdef SDIV_DIVZERO_EN
         LOAD: next_state = (dvs == '0) ? DONE : ITER;
`else
         LOAD: next_state = ITER;
`endif
         ITER: if (count == LAST) next_state = FIX;
         FIX:  next_state = DONE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state != IDLE);
      bus.done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         dvd    <= '0;
         dvs    <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         a_reg  <= '0;
         p_reg  <= '0;
         d_reg  <= '0;
         quo    <= '0;
         rem    <= '0;
`ifdef SDIV_DIVZERO_EN
         dz     <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: if (bus.start) begin
               dvd    <= bus.dividend;
               dvs    <= bus.divisor;
               sign_q <= bus.dividend[W-1] ^ bus.divisor[W-1];
               sign_r <= bus.dividend[W-1];
`ifdef SDIV_DIVZERO_EN
               dz     <= 1'b0;
`endif
            end
            LOAD: begin
               a_reg <= dvd_mag;
               d_reg <= dvs_mag;
               p_reg <= '0;
               count <= '0;
`ifdef SDIV_DIVZERO_EN
               if (dvs == '0) begin
                  quo <= '1;
                  rem <= dvd;
                  dz  <= 1'b1;
               end
`endif
            end
            ITER: begin
               p_reg <= p_next;
               a_reg <= a_next;
               count <= count + CW'(1);
            end
            FIX: begin
               quo <= sign_q ? -a_reg : a_reg;
               rem <= sign_r ? -p_reg[W-1:0] : p_reg[W-1:0];
            end
            default: ;
         endcase
      end
   end

   assign bus.quotient  = quo;
   assign bus.remainder = rem;
`ifdef SDIV_DIVZERO_EN
   assign bus.div_by_zero = dz;
`endif

endmodule

`default_nettype wire
